// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle byte/halfword/word data memory with wait states,
// req/ready handshake and misalignment detection. Rev 1.0
`default_nettype none

module data_mem_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 8192,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              busy,
  output logic              misalign
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              we_q;
  logic              sign_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [31:0] mem [DEPTH];

  logic [IDX_W-1:0] idx;
  logic             done;
  logic             req_misaligned;
  logic [3:0]       be;
  logic [31:0]      st_data;
  logic [31:0]      rword;
  logic [7:0]       rbyte;
  logic [15:0]      rhalf;
  logic [31:0]      load_val;
  logic             unused_ok;

  // Upper address bits beyond the memory depth simply alias.
  assign idx       = addr_q[IDX_W+1:2];
  assign done      = (state == S_WAIT) && (cnt == 4'd0);
  assign unused_ok = ^addr_q;

  always_comb begin
    req_misaligned = 1'b0;
    case (size)
      2'b01:   req_misaligned = addr[0];
      2'b10:   req_misaligned = (addr[1:0] != 2'b00);
      2'b11:   req_misaligned = 1'b1;
      default: req_misaligned = 1'b0;
    endcase
  end

  // Sub-word stores replicate the low lane so the byte enables pick the target.
  always_comb begin
    be      = 4'b1111;
    st_data = wdata_q;
    case (size_q)
      2'b00: begin
        be      = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be      = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    rword = mem[idx];
    rbyte = rword[{addr_q[1:0], 3'b000} +: 8];
    rhalf = addr_q[1] ? rword[31:16] : rword[15:0];
    case (size_q)
      2'b00:   load_val = {{24{sign_q & rbyte[7]}}, rbyte};
      2'b01:   load_val = {{16{sign_q & rhalf[15]}}, rhalf};
      default: load_val = rword;
    endcase
  end

  always_ff @(posedge clk) begin
    if (done && we_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= st_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      we_q     <= 1'b0;
      sign_q   <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata    <= 32'd0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      misalign <= 1'b0;
    end else begin
      ready    <= 1'b0;
      misalign <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            busy <= 1'b1;
            if (req_misaligned) begin
              state <= S_ERR;
            end else begin
              we_q    <= we;
              size_q  <= size;
              sign_q  <= sign;
              addr_q  <= addr;
              wdata_q <= wdata;
              cnt     <= WAIT_CNT;
              state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            ready <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
            if (!we_q) rdata <= load_val;
          end
        end
        S_ERR: begin
          ready    <= 1'b1;
          misalign <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed scoreboard bench for data_mem_ctrl (WAIT=2). Rev 1.0
`default_nettype none

module tb_data_mem_ctrl;

  localparam int WAIT_P = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign = 1'b0;
  logic [15:0] addr = 16'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        misalign;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] model_rd = 32'd0;

  data_mem_ctrl #(.ADDR_W(16), .DEPTH(8192), .WAIT(WAIT_P)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign(sign),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction: drive, push expectation at accept, pop at ready.
  task automatic access(input string tag, input logic w, input logic [1:0] sz,
                        input logic sg, input logic [15:0] a, input logic [31:0] wd,
                        input logic [31:0] load_exp, input logic mis);
    exp_t e;
    int   lat;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sign = sg; addr = a; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0;
    e.mis = mis;
    e.lat = mis ? 1 : WAIT_P + 1;
    e.rd  = (!mis && !w) ? load_exp : model_rd;
    sb_q.push_back(e);
    chk({tag, "_busy_at_accept"}, 32'(busy), 32'd1);
    chk({tag, "_ready_at_accept"}, 32'(ready), 32'd0);
    lat = 0;
    while (ready !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb_q.pop_front();
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
    chk({tag, "_misalign"}, 32'(misalign), 32'(e.mis));
    chk({tag, "_rdata"}, rdata, e.rd);
    chk({tag, "_busy_at_ready"}, 32'(busy), 32'd0);
    model_rd = e.rd;
  endtask

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_misalign", 32'(misalign), 32'd0);

    // Word and sub-word accesses
    access("sw_10",   1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0);
    access("lw_10",   1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0);
    access("sb_11",   1'b1, 2'b00, 1'b0, 16'h0011, 32'h1234567F, 32'h0, 1'b0);
    access("lw_10b",  1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 32'hDEAD7FEF, 1'b0);
    access("lb_13",   1'b0, 2'b00, 1'b1, 16'h0013, 32'h0, 32'hFFFFFFDE, 1'b0);
    access("lhu_12",  1'b0, 2'b01, 1'b0, 16'h0012, 32'h0, 32'h0000DEAD, 1'b0);
    access("lh_12",   1'b0, 2'b01, 1'b1, 16'h0012, 32'h0, 32'hFFFFDEAD, 1'b0);
    access("lbu_11",  1'b0, 2'b00, 1'b0, 16'h0011, 32'h0, 32'h0000007F, 1'b0);
    access("lb_10",   1'b0, 2'b00, 1'b1, 16'h0010, 32'h0, 32'hFFFFFFEF, 1'b0);
    access("lh_10",   1'b0, 2'b01, 1'b1, 16'h0010, 32'h0, 32'h00007FEF, 1'b0);
    access("sh_12",   1'b1, 2'b01, 1'b0, 16'h0012, 32'hAAAA8001, 32'h0, 1'b0);
    access("lh_12b",  1'b0, 2'b01, 1'b1, 16'h0012, 32'h0, 32'hFFFF8001, 1'b0);

    // Misaligned requests: no write, rdata held
    access("mis_lh_01", 1'b0, 2'b01, 1'b1, 16'h0001, 32'h0, 32'h0, 1'b1);
    access("mis_lw_02", 1'b0, 2'b10, 1'b0, 16'h0002, 32'h0, 32'h0, 1'b1);
    access("mis_sw_12", 1'b1, 2'b10, 1'b0, 16'h0012, 32'h00000000, 32'h0, 1'b1);
    access("mis_sz11",  1'b1, 2'b11, 1'b0, 16'h0010, 32'h00000000, 32'h0, 1'b1);
    access("lw_10c",    1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 32'h80017FEF, 1'b0);

    // Requests held during busy are ignored
    access("sw_20", 1'b1, 2'b10, 1'b0, 16'h0020, 32'h11111111, 32'h0, 1'b0);
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; sign = 1'b0; addr = 16'h0010;
    @(posedge clk); #1;
    e.rd = 32'h80017FEF; e.mis = 1'b0; e.lat = WAIT_P + 1;
    sb_q.push_back(e);
    chk("hold_busy_accept", 32'(busy), 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      we = 1'b1; size = 2'b00; addr = 16'h0020 + 16'(i); wdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      chk("hold_busy_mid", 32'(busy), 32'd1);
      chk("hold_ready_mid", 32'(ready), 32'd0);
    end
    @(negedge clk);
    addr = 16'h0022;
    @(posedge clk); #1;
    req = 1'b0;
    e = sb_q.pop_front();
    chk("hold_ready", 32'(ready), 32'd1);
    chk("hold_rdata", rdata, e.rd);
    model_rd = e.rd;
    repeat (4) @(posedge clk);
    #1;
    chk("hold_no_extra_busy", 32'(busy), 32'd0);
    chk("hold_no_extra_ready", 32'(ready), 32'd0);
    access("lw_20", 1'b0, 2'b10, 1'b0, 16'h0020, 32'h0, 32'h11111111, 1'b0);

    // Address wrap beyond DEPTH*4
    access("sw_wrap", 1'b1, 2'b10, 1'b0, 16'h8004, 32'hCAFEF00D, 32'h0, 1'b0);
    access("lw_04",   1'b0, 2'b10, 1'b0, 16'h0004, 32'h0, 32'hCAFEF00D, 1'b0);

    // Reset mid-access aborts the store
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 16'h0004; wdata = 32'h12345678;
    @(posedge clk); #1;
    req = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy_low", 32'(busy), 32'd0);
    chk("rst_mid_ready", 32'(ready), 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    model_rd = 32'd0;
    access("lw_04_after_rst", 1'b0, 2'b10, 1'b0, 16'h0004, 32'h0, 32'hCAFEF00D, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised, multi-cycle data memory controller that replaces the fixed single-cycle word-only data memory in the MIPS datapath. It adds byte and halfword accesses (lb/lbu/lh/lhu/sb/sh as well as lw/sw), with little-endian lane steering and sign or zero extension. It also adds a configurable wait-state counter with a req/ready handshake and misalignment detection. It sits between the ALU address output / RegFile read data 2 and the MemtoReg write-back mux; the multi-cycle control FSM stalls the PC while `busy` is high.

## Interface
Parameters:
- ADDR_W, 16, byte-address width.
- DEPTH, 8192, number of 32-bit words; power of two, DEPTH*4 <= 2^ADDR_W.
- WAIT, 2, wait-state cycles per aligned access; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  access request; sampled only when busy=0.
- we  in  1  1 = store, 0 = load; sampled with req.
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- sign  in  1  1 = sign-extend loads, 0 = zero-extend; ignored for word and store accesses.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data; the low byte or low halfword is used for sub-word stores.
- rdata  out  32  registered load result; holds its value until the next completed load.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high from request accept until completion.
- misalign  out  1  one-cycle error pulse, coincident with ready.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - WAIT: wait-state counter cnt running.
  - ERR: misaligned request, one cycle.
- IDLE, req=1, aligned: latch we/size/sign/addr/wdata, load cnt=WAIT, go to WAIT, busy=1.
- IDLE, req=1, misaligned: go to ERR, busy=1.
  - Misaligned means size=01 with addr[0]=1, size=10 with addr[1:0]!=0, or size=11.
- WAIT: each edge, if cnt!=0 then cnt decrements; if cnt==0 the access is performed on that edge, ready=1, busy=0, and the FSM returns to IDLE.
- ERR: on the next edge ready=1, misalign=1, busy=0, return to IDLE. No memory write occurs and rdata is unchanged.
- Word index is addr[ADDR_W-1:2] modulo DEPTH; addresses above DEPTH*4 wrap.
- Byte lane is addr[1:0]; halfword lane is addr[1]. Lanes are little-endian (lane 0 = bits 7:0).
- Stores write only the addressed lane(s); the other bytes of the word are preserved.
- Loads: the selected byte or half is right-justified, then extended according to sign.
- req while busy=1 is ignored; it is neither queued nor an error.
- Memory contents are not reset. rdata is reset to 0.

## Timing
- Reset values: rdata=0, ready=0, busy=0, misalign=0, FSM in IDLE, cnt=0.
- Asserting rst_n low mid-access aborts the access immediately: no write occurs and the controller returns to IDLE.
- Aligned latency: request accepted at edge E0; ready high during the cycle after edge E0+WAIT+1. For WAIT=0, ready follows E0+1.
- Misaligned latency: ready and misalign are high after E0+1, independent of WAIT.
- busy is high after E0 and low in the same cycle that ready is high.
- A new req may be accepted on the edge that ends the ready cycle. Peak throughput is one access per WAIT+2 cycles.
- rdata updates on the completing edge, so it is valid in the same cycle as ready.

## Test plan
- Reset: hold rst_n=0, then release → rdata=0, ready=0, busy=0, misalign=0.
- WAIT=2: sw 0xDEADBEEF to 0x0010, then lw 0x0010 → each ready arrives 3 edges after accept; rdata=0xDEADBEEF.
- Sub-word store: sb 0x7F to 0x0011 over the stored word → lw 0x0010 gives 0xDEAD7FEF. lb with sign=1 at 0x0013 → 0xFFFFFFDE. lhu at 0x0012 → 0x0000DEAD.
- Misalignment: lh at 0x0001 and lw at 0x0002 → ready and misalign pulse one edge after accept; memory and rdata unchanged. size=11 → same response.
- Busy/wrap: assert req continuously with changing addr during busy → only the first request is serviced. sw to DEPTH*4+4 aliases with lw at address 4.
- Reset mid-access: sw accepted, rst_n low at cycle 1 → after release, lw at the same address returns the prior contents.
